// File: rtl/uart_tx_arbiter_pkg.sv
// Shared frame constants and transmitter state type for the arbitrated UART transmitter.
package uart_tx_arbiter_pkg;

    localparam int FrameBits = 10;
    localparam int DataBits  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART frame engine: one start bit, eight data bits LSB first, one stop bit,
// each bit held for ClksPerBit cycles.
module uart_tx_serializer
    import uart_tx_arbiter_pkg::*;
#(
    parameter int ClksPerBit = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       tx,
    output logic       busy
);

    localparam int                CntW    = $clog2(ClksPerBit);
    localparam logic [CntW-1:0]   CntMax  = CntW'(ClksPerBit - 1);
    localparam logic [2:0]        LastBit = 3'(DataBits - 1);

    tx_state_e           state;
    logic [CntW-1:0]     baud_cnt;
    logic [2:0]          bit_idx;
    logic [DataBits-1:0] shreg;
    logic                bit_end;

    assign bit_end = (baud_cnt == CntMax);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg    <= data;
                        baud_cnt <= '0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_idx == LastBit) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The line level follows the state directly so reset forces idle-high at once.
    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shreg[0];
            default:  tx = 1'b1;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_STOP) && bit_end;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-packet locking and idle timeout, feeding
// several byte streams into a single UART transmitter.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NumReq         = 2,
    parameter int ClockFrequency = 30_000_000,
    parameter int BaudRate       = 921_600,
    parameter int TimeoutCycles  = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [NumReq*8-1:0]   req_data_i,
    input  logic [NumReq-1:0]     req_last_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic [NumReq-1:0]     grant_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int ClksPerBit = ClockFrequency / BaudRate;
    localparam int IdxW       = $clog2(NumReq);
    localparam int ToW        = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    localparam logic [ToW-1:0]  ToLast = ToW'(TimeoutCycles - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(NumReq - 1);

    if (ClksPerBit < 4 || NumReq < 2 || NumReq > 8) begin : g_bad_params
        $error("uart_tx_arbiter: needs ClksPerBit >= 4 and 2 <= NumReq <= 8");
    end

    logic            locked;
    logic [IdxW-1:0] owner;
    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] pick_idx;
    logic            pick_found;
    logic [7:0]      pick_data;
    logic            accept;
    logic            ser_busy;
    logic            ser_done;
    logic            owner_waiting;
    logic            timeout_hit;
    logic [ToW-1:0]  idle_cnt;
    int              cand;

    // A locked packet only ever considers its owner; otherwise scan from rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = owner;
        cand       = 0;
        if (locked) begin
            pick_found = req_valid_i[owner];
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                cand = int'(rr_ptr) + k;
                if (cand >= NumReq) begin
                    cand = cand - NumReq;
                end
                if (!pick_found && req_valid_i[cand]) begin
                    pick_found = 1'b1;
                    pick_idx   = IdxW'(cand);
                end
            end
        end
    end

    assign pick_data     = req_data_i[int'(pick_idx)*8 +: 8];
    assign accept        = pick_found && !ser_busy;
    assign owner_waiting = locked && !ser_busy && !req_valid_i[owner];
    assign timeout_hit   = (TimeoutCycles != 0) && owner_waiting && (idle_cnt == ToLast);

    always_comb begin
        req_ready_o = '0;
        grant_o     = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_ready_o[i] = accept && (pick_idx == IdxW'(i));
            grant_o[i]     = locked && (owner == IdxW'(i));
        end
    end

    // Idle counting restarts at every frame end, so the timeout is measured from IDLE entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            locked   <= 1'b0;
            owner    <= '0;
            rr_ptr   <= '0;
            idle_cnt <= '0;
        end else if (accept) begin
            locked   <= !req_last_i[pick_idx];
            owner    <= pick_idx;
            rr_ptr   <= (pick_idx == IdxMax) ? '0 : pick_idx + 1'b1;
            idle_cnt <= '0;
        end else if (timeout_hit) begin
            locked   <= 1'b0;
            idle_cnt <= '0;
        end else if (ser_done) begin
            idle_cnt <= '0;
        end else if (owner_waiting && (TimeoutCycles != 0)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    uart_tx_serializer #(
        .ClksPerBit (ClksPerBit)
    ) u_serializer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start  (accept),
        .data   (pick_data),
        .done   (ser_done),
        .tx     (tx_o),
        .busy   (ser_busy)
    );

    assign busy_o = ser_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios with literal
// expectations plus a randomized run against a frame-timing reference model.
module tb_uart_tx_arbiter;

    localparam int NR    = 3;
    localparam int CPB   = 30_000_000 / 921_600;
    localparam int TO    = 100;
    localparam int IdleT = 1_000_000;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } item_t;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   grant;
    logic            tx;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(
        .NumReq         (NR),
        .ClockFrequency (30_000_000),
        .BaudRate       (921_600),
        .TimeoutCycles  (TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .tx_o        (tx),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at t=%0t: got %0h, wanted %0h", name, $time, actual, expected);
        end
    endtask

    // Requester drivers: each presents queued bytes and holds them until accepted.
    item_t req_q [NR][$];
    item_t cur   [NR];
    bit    pres  [NR];
    bit    have  [NR];
    int    gap   [NR];
    bit    random_mode;

    task automatic push_packet(input int i);
        int len;
        item_t it;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
            it.data = 8'($urandom);
            it.last = (b == len - 1);
            if (b == 0)                            it.gap = $urandom_range(0, 30);
            else if ($urandom_range(0, 5) == 0)    it.gap = $urandom_range(60, 220);
            else                                   it.gap = $urandom_range(0, 4);
            req_q[i].push_back(it);
        end
    endtask

    task automatic apply_stimulus(input logic [NR-1:0] rdy);
        for (int i = 0; i < NR; i++) begin
            if (pres[i] && rdy[i]) begin
                pres[i] = 1'b0;
                have[i] = 1'b0;
            end
            if (random_mode && !have[i] && req_q[i].size() == 0 && $urandom_range(0, 9) == 0)
                push_packet(i);
            if (!have[i] && req_q[i].size() > 0) begin
                cur[i]  = req_q[i].pop_front();
                have[i] = 1'b1;
                gap[i]  = cur[i].gap;
            end
            if (have[i] && !pres[i]) begin
                if (gap[i] == 0) pres[i] = 1'b1;
                else             gap[i]--;
            end
            req_valid[i]       = pres[i];
            req_data[i*8 +: 8] = cur[i].data;
            req_last[i]        = cur[i].last;
        end
    endtask

    task automatic clear_driver();
        for (int i = 0; i < NR; i++) begin
            req_q[i].delete();
            pres[i]     = 1'b0;
            have[i]     = 1'b0;
            gap[i]      = 0;
            cur[i].data = 8'h00;
            cur[i].last = 1'b0;
            cur[i].gap  = 0;
        end
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
    endtask

    // Per-run traces indexed by cycle since the run started.
    int tr_tx[$];
    int tr_busy[$];
    int tr_grant[$];
    int acc_idx[$];
    int acc_cyc[$];

    function automatic int tr_at(input int kind, input int i);
        if (i < 0 || i >= tr_tx.size()) return -1;
        if (kind == 0) return tr_tx[i];
        if (kind == 1) return tr_busy[i];
        return tr_grant[i];
    endfunction

    function automatic int acc_i(input int n);
        return (n < acc_idx.size()) ? acc_idx[n] : -1;
    endfunction

    function automatic int acc_c(input int n);
        return (n < acc_cyc.size()) ? acc_cyc[n] : -1;
    endfunction

    function automatic int lowest_bit(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic run_cycles(input int n);
        logic [NR-1:0] rdy;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rdy = req_ready;
            tr_tx.push_back(int'(tx));
            tr_busy.push_back(int'(busy));
            tr_grant.push_back(int'(grant));
            if (rdy != '0) begin
                acc_idx.push_back(lowest_bit(rdy));
                acc_cyc.push_back(tr_tx.size() - 1);
            end
            @(posedge clk);
            #1;
            apply_stimulus(rdy);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_driver();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tr_tx.delete();
        tr_busy.delete();
        tr_grant.delete();
        acc_idx.delete();
        acc_cyc.delete();
    endtask

    // Reference model: frame position from cycles since acceptance, plus lock/round-robin rules.
    int            m_t;
    int            m_last;
    int            m_owner;
    int            m_idle;
    bit            m_locked;
    logic [7:0]    m_byte;
    int            m_pick;
    int            m_bitpos;
    int            m_j;
    bit            m_in_frame;
    logic          m_tx;
    logic [NR-1:0] m_ready;
    logic [NR-1:0] m_grant;
    logic [NR-1:0]   prev_valid;
    logic [NR-1:0]   prev_ready;
    logic [NR-1:0]   prev_last;
    logic [NR*8-1:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_t      = IdleT;
            m_last   = NR - 1;
            m_owner  = 0;
            m_idle   = 0;
            m_locked = 1'b0;
            m_byte   = 8'h00;
            prev_valid = '0;
            prev_ready = '0;
            prev_last  = '0;
            prev_data  = '0;
            check_output("reset_tx",    32'(tx),        32'd1);
            check_output("reset_busy",  32'(busy),      32'd0);
            check_output("reset_ready", 32'(req_ready), 32'd0);
            check_output("reset_grant", 32'(grant),     32'd0);
        end else begin
            m_in_frame = (m_t >= 1) && (m_t <= 10 * CPB);
            m_tx = 1'b1;
            if (m_in_frame) begin
                m_bitpos = (m_t - 1) / CPB;
                if (m_bitpos == 0)      m_tx = 1'b0;
                else if (m_bitpos <= 8) m_tx = m_byte[m_bitpos-1];
            end
            m_grant = m_locked ? (NR'(1) << m_owner) : '0;
            m_pick  = -1;
            if (!m_in_frame) begin
                if (m_locked) begin
                    if (req_valid[m_owner]) m_pick = m_owner;
                end else begin
                    for (int k = 0; k < NR; k++) begin
                        m_j = (m_last + 1 + k) % NR;
                        if (m_pick < 0 && req_valid[m_j]) m_pick = m_j;
                    end
                end
            end
            m_ready = (m_pick >= 0) ? (NR'(1) << m_pick) : '0;

            check_output("model_tx",    32'(tx),        32'(m_tx));
            check_output("model_busy",  32'(busy),      32'(m_in_frame));
            check_output("model_ready", 32'(req_ready), 32'(m_ready));
            check_output("model_grant", 32'(grant),     32'(m_grant));

            for (int i = 0; i < NR; i++) begin
                if (prev_valid[i] && !prev_ready[i])
                    check_output("req_hold_stable",
                                 {23'd0, req_valid[i], req_last[i], req_data[i*8 +: 8]},
                                 {23'd0, 1'b1, prev_last[i], prev_data[i*8 +: 8]});
            end
            prev_valid = req_valid;
            prev_ready = req_ready;
            prev_last  = req_last;
            prev_data  = req_data;

            if (m_t < IdleT) m_t++;
            if (m_pick >= 0) begin
                m_t      = 1;
                m_byte   = req_data[m_pick*8 +: 8];
                m_last   = m_pick;
                m_owner  = m_pick;
                m_locked = !req_last[m_pick];
                m_idle   = 0;
            end else if (m_locked && !m_in_frame && !req_valid[m_owner]) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_locked = 1'b0;
                    m_idle   = 0;
                end
            end
        end
    end

    logic exp_bits [10];
    int   busy_sum;

    initial begin
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        random_mode = 1'b0;
        rst_n = 1'b1;
        clear_driver();
        #1;

        // Single byte 0xA5 from requester 0.
        do_reset();
        req_q[0].push_back('{8'hA5, 1'b1, 0});
        apply_stimulus('0);
        run_cycles(340);
        check_output("A_accept_count", 32'(acc_idx.size()), 32'd1);
        check_output("A_accept_idx",   32'(acc_i(0)),       32'd0);
        for (int b = 0; b < 10; b++)
            check_output($sformatf("A_tx_bit%0d", b), 32'(tr_at(0, acc_c(0) + 17 + CPB * b)), 32'(exp_bits[b]));
        busy_sum = 0;
        foreach (tr_busy[k]) busy_sum += tr_busy[k];
        check_output("A_busy_cycles", 32'(busy_sum), 32'd320);

        // All requesters continuously valid: strict rotation, 321 cycles apart.
        do_reset();
        for (int i = 0; i < NR; i++)
            for (int n = 0; n < 6; n++) req_q[i].push_back('{8'(8'h10 * i + n), 1'b1, 0});
        apply_stimulus('0);
        run_cycles(1400);
        check_output("B_idx0", 32'(acc_i(0)), 32'd0);
        check_output("B_idx1", 32'(acc_i(1)), 32'd1);
        check_output("B_idx2", 32'(acc_i(2)), 32'd2);
        check_output("B_idx3", 32'(acc_i(3)), 32'd0);
        for (int n = 1; n < 4; n++)
            check_output($sformatf("B_gap%0d", n), 32'(acc_c(n) - acc_c(n - 1)), 32'd321);

        // Packet lock: requester 0 sends three bytes while requester 1 waits.
        do_reset();
        req_q[0].push_back('{8'h11, 1'b0, 0});
        req_q[0].push_back('{8'h22, 1'b0, 0});
        req_q[0].push_back('{8'h33, 1'b1, 0});
        req_q[1].push_back('{8'h77, 1'b1, 0});
        apply_stimulus('0);
        run_cycles(1000);
        check_output("C_idx0", 32'(acc_i(0)), 32'd0);
        check_output("C_idx1", 32'(acc_i(1)), 32'd0);
        check_output("C_idx2", 32'(acc_i(2)), 32'd0);
        check_output("C_idx3", 32'(acc_i(3)), 32'd1);
        check_output("C_grant_in_packet",  32'(tr_at(2, acc_c(1))),     32'd1);
        check_output("C_grant_last_cycle", 32'(tr_at(2, acc_c(2))),     32'd1);
        check_output("C_grant_after_last", 32'(tr_at(2, acc_c(2) + 1)), 32'd0);

        // Lock timeout: owner goes quiet after a non-final byte.
        do_reset();
        req_q[0].push_back('{8'h5A, 1'b0, 0});
        req_q[1].push_back('{8'h66, 1'b1, 0});
        apply_stimulus('0);
        run_cycles(800);
        check_output("D_idx0", 32'(acc_i(0)), 32'd0);
        check_output("D_idx1", 32'(acc_i(1)), 32'd1);
        check_output("D_gap",  32'(acc_c(1) - acc_c(0)), 32'd421);
        check_output("D_grant_before_clear", 32'(tr_at(2, acc_c(1) - 1)), 32'd1);
        check_output("D_grant_cleared",      32'(tr_at(2, acc_c(1))),     32'd0);

        // Reset during data bit 3 aborts the frame immediately.
        do_reset();
        req_q[1].push_back('{8'hC3, 1'b1, 0});
        apply_stimulus('0);
        run_cycles(141);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("E_tx_at_reset",    32'(tx),        32'd1);
        check_output("E_busy_at_reset",  32'(busy),      32'd0);
        check_output("E_ready_at_reset", 32'(req_ready), 32'd0);
        check_output("E_grant_at_reset", 32'(grant),     32'd0);
        do_reset();
        for (int i = 0; i < NR; i++) req_q[i].push_back('{8'(8'hE0 + i), 1'b1, 0});
        apply_stimulus('0);
        run_cycles(30);
        check_output("E_accept_count", 32'(acc_idx.size()), 32'd1);
        check_output("E_first_idx",    32'(acc_i(0)),       32'd0);

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        random_mode = 1'b1;
        apply_stimulus('0);
        run_cycles(30000);
        check_output("R_made_progress", 32'(acc_idx.size() > 20), 32'd1);
        random_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter ClockFrequency, default 30_000_000, clk_i frequency in Hz.
REQ-003 SHALL have parameter BaudRate, default 921_600, serial line rate in bit/s.
REQ-004 SHALL have parameter TimeoutCycles, default 1024, idle cycles before a held packet lock is forcibly released (0 disables).
REQ-005 SHALL have port clk_i  input  1  single clock for all logic.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid_i  input  NumReq  per-requester byte valid.
REQ-008 SHALL have port req_data_i  input  NumReq x 8  per-requester byte.
REQ-009 SHALL have port req_last_i  input  NumReq  byte ends the requester's packet.
REQ-010 SHALL have port req_ready_o  output  NumReq  one-cycle accept pulse, at most one bit set.
REQ-011 SHALL have port grant_o  output  NumReq  one-hot current lock owner, zero when unlocked.
REQ-012 SHALL have port tx_o  output  1  serial line to UART receiver, idle high.
REQ-013 SHALL have port busy_o  output  1  high while a frame is on tx_o.

Function
REQ-014 SHALL derive ClksPerBit = floor(ClockFrequency/BaudRate) (32 at defaults); elaboration SHALL fail if ClksPerBit < 4.
REQ-015 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE; START, each of 8 DATA bits, and STOP each last exactly ClksPerBit cycles.
REQ-016 SHALL accept a byte only in IDLE: req_ready_o[i] high for one cycle, req_data_i[i] captured that cycle, FSM to START next cycle.
REQ-017 SHALL drive tx_o low for START starting the cycle after acceptance, DATA LSB first, high for STOP; frame = 10*ClksPerBit cycles; minimum one IDLE cycle between frames.
REQ-018 SHALL assert busy_o exactly while FSM is in START, DATA or STOP.
REQ-019 When unlocked, SHALL pick the first valid requester searching round-robin from index (last accepted + 1) mod NumReq.
REQ-020 When accepted byte has req_last_i=0, SHALL lock to that requester (grant_o one-hot) and accept only it until it sends a byte with req_last_i=1.
REQ-021 SHALL clear the lock in the acceptance cycle of a req_last_i=1 byte; grant_o zero from the next cycle.
REQ-022 While locked and in IDLE with owner req_valid_i low, SHALL count cycles; at TimeoutCycles SHALL clear the lock and resume REQ-019 the following cycle; counter resets on owner accept or lock clear.
REQ-023 Requesters SHALL hold req_valid_i/req_data_i/req_last_i stable until ready; bench SHALL assert this, block behaviour otherwise undefined.
REQ-024 Simultaneous valid on all requesters with no lock SHALL yield strict rotation 0,1,...,NumReq-1,0.

Reset
REQ-025 On rst_ni low, SHALL immediately force tx_o=1, busy_o=0, req_ready_o=0, grant_o=0, FSM=IDLE, lock cleared, timeout counter 0, round-robin pointer so requester 0 has highest priority.
REQ-026 Reset mid-frame SHALL abort the frame without completing it; no byte SHALL be re-sent after release.

Structure
REQ-027 SHALL place FSM state enum, FrameBits=10 and DataBits=8 constants in package uart_tx_arbiter_pkg.
REQ-028 SHALL contain one sub-module uart_tx_serializer (baud counter, shift register, FSM, tx_o, busy_o, done pulse); arbitration, lock and timeout in the top.

Verification (defaults, ClksPerBit=32)
REQ-029 req0 sends 0xA5 last=1 -> one ready pulse; tx_o low 32 cycles, then 1,0,1,0,0,1,0,1 each 32 cycles, high stop; busy_o high 320 cycles.
REQ-030 req0, req1 continuously valid, last=1, from reset -> acceptance order 0,1,0,1; 321 cycles between accepts.
REQ-031 req0 sends 0x11,0x22,0x33 (last on 0x33), req1 valid throughout -> req1 accepted only after 0x33; grant_o=01 during packet.
REQ-032 TimeoutCycles=100, req0 sends last=0 then drops valid, req1 valid -> grant_o clears 100 cycles after IDLE entry; req1 accepted next cycle.
REQ-033 rst_ni low during DATA bit 3 -> tx_o=1, busy_o=0 same cycle; after release first accept goes to requester 0.
